countdown_timer: RTL and testbench

Loadable down-counter/timer: the counting complement of the team's synchronous up-counter, sharing its clocking style (falling-edge update, synchronous reset, count enable). A reload value is captured, a start command arms the count, and the block decrements on each enabled edge, flagging terminal count with a one-cycle pulse. It sits next to the up-counters in the FPGA-architecture examples as the timer/prescaler source for downstream logic.

---
 rtl/countdown_pkg.sv | 12 +
 rtl/countdown_timer.sv | 84 ++++++++
 tb/tb_countdown_timer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.
package countdown_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle terminal-count pulse, updated on the falling edge.
// Define COUNTDOWN_AUTORELOAD_EN to make RUN reload and keep counting at terminal count.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             tc_q, tc_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            reload_d = load_val;
            count_d  = load_val;
            state_d  = IDLE;
        end else if (start && state_q != RUN) begin
            count_d = reload_q;
            if (reload_q != '0) begin
                state_d = RUN;
            end else begin
                tc_d    = 1'b1;
                state_d = DONE;
            end
        end else if (state_q == RUN && en) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                count_d = reload_q;
                tc_d    = 1'b1;
`else
                // Saturate at zero: a count of 0 in RUN cannot occur, but never wrap.
                count_d = '0;
                tc_d    = 1'b1;
                state_d = DONE;
`endif
            end
        end

        busy_d = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer; expectations follow COUNTDOWN_AUTORELOAD_EN when defined.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;

    int n_checks = 0;
    int n_errors = 0;

    logic [W+1:0] exp_q[$];
    string        tag_q[$];

    countdown_timer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .count    (count),
        .busy     (busy),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got count=%0d busy=%b tc=%b, expected count=%0d busy=%b tc=%b",
                     tag, got[W+1:2], got[1], got[0], exp[W+1:2], exp[1], exp[0]);
        end
    endtask

    // Drive one edge's inputs, queue the expected outputs, compare after the falling edge.
    task automatic step(input bit r, input bit ld, input bit st, input bit e,
                        input logic [W-1:0] lv, input logic [W-1:0] ec,
                        input bit eb, input bit et, input string tag);
        logic [W+1:0] got;
        @(posedge clk);
        rst = r; load = ld; start = st; en = e; load_val = lv;
        exp_q.push_back({ec, eb, et});
        tag_q.push_back(tag);
        @(negedge clk);
        #1;
        got = {count, busy, tc};
        check(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    // After a start with reload r, run n edges; alt gives en low,high,low,high...
    task automatic run_seq(input int r, input int n, input bit alt, input string name);
        int  k = 0;
        bit  done = 0;
        bit  e;
        logic [W-1:0] ec;
        bit  eb, et;
        for (int i = 0; i < n; i++) begin
            e = alt ? bit'(i % 2) : 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            if (e) k++;
            ec = W'(r - (k % r));
            eb = 1'b1;
            et = e && (k % r == 0);
`else
            et = 1'b0;
            if (e && !done) begin
                k++;
                if (k == r) begin
                    done = 1;
                    et   = 1'b1;
                end
            end
            ec = done ? W'(0) : W'(r - k);
            eb = !done;
`endif
            step(0, 0, 0, e, '0, ec, eb, et, $sformatf("%s_%0d", name, i));
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, "reset_a");
        step(1, 0, 0, 0, 0, 0, 0, 0, "reset_b");

        // Straight run of 5 with en high, plus extra edges after terminal count.
        step(0, 1, 0, 0, 5, 5, 0, 0, "load5");
        step(0, 0, 1, 1, 0, 5, 1, 0, "start5");
        run_seq(5, 7, 0, "run5");

        // Alternating enable doubles the run length.
        step(0, 1, 0, 0, 5, 5, 0, 0, "load5_alt");
        step(0, 0, 1, 0, 0, 5, 1, 0, "start5_alt");
        run_seq(5, 12, 1, "alt5");

        // Zero reload: immediate tc, busy never rises.
        step(0, 1, 0, 0, 0, 0, 0, 0, "load0");
        step(0, 0, 1, 1, 0, 0, 0, 1, "start0");
        step(0, 0, 0, 1, 0, 0, 0, 0, "after0");

        // Maximum reload.
        step(0, 1, 0, 0, 15, 15, 0, 0, "load15");
        step(0, 0, 1, 1, 0, 15, 1, 0, "start15");
        run_seq(15, 17, 0, "run15");

        // Load aborts a run at count 3 without tc; en is then ignored in IDLE.
        step(0, 1, 0, 0, 5, 5, 0, 0, "load5_abort");
        step(0, 0, 1, 1, 0, 5, 1, 0, "start_abort");
        step(0, 0, 0, 1, 0, 4, 1, 0, "abort_4");
        step(0, 0, 0, 1, 0, 3, 1, 0, "abort_3");
        step(0, 1, 0, 1, 9, 9, 0, 0, "load9_mid");
        step(0, 0, 0, 1, 0, 9, 0, 0, "idle_en");

        // Load wins over start on the same edge; start in RUN does not restart.
        step(0, 1, 1, 1, 4, 4, 0, 0, "load_vs_start");
        step(0, 0, 1, 1, 0, 4, 1, 0, "start4");
        step(0, 0, 0, 1, 0, 3, 1, 0, "run4_3");
        step(0, 0, 1, 1, 0, 2, 1, 0, "restart_ignored");

        // Reset mid-run for two edges, overriding load/start.
        step(1, 1, 1, 1, 7, 0, 0, 0, "rst_mid_a");
        step(1, 0, 1, 1, 0, 0, 0, 0, "rst_mid_b");
        step(0, 0, 0, 1, 0, 0, 0, 0, "post_rst_idle");
        step(0, 0, 1, 1, 0, 0, 0, 1, "post_rst_start_zero");

        // Reload of 3: one-shot by default, periodic with auto-reload.
        step(0, 1, 0, 0, 3, 3, 0, 0, "load3");
        step(0, 0, 1, 1, 0, 3, 1, 0, "start3");
        run_seq(3, 7, 0, "run3");
        step(0, 1, 0, 1, 2, 2, 0, 0, "load2_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
